// File: rtl/uart_tx_128bits.sv
// UART transmitter for a 128-bit frame: 16 bytes (full) or 8 bytes (short, state==9),
// most-significant byte first, 8N1 with optional idle gap after each stop bit.
module uart_tx_128bits #(
  parameter int CLK_FREQ = 40_000_000,
  parameter int BAUD     = 115200,
  parameter int GAP_BITS = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [7:0]   state,
  input  logic [127:0] tx_data,
  input  logic         tx_start,
  output logic         tx_busy,
  output logic         tx_done,
  output logic [1:0]   word_cnt,
  output logic         uart_tx
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [3:0] GAP_LAST = 4'((GAP_BITS == 0) ? 0 : GAP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_GAP,
    S_DONE
  } fsm_t;

  fsm_t           fsm_q, fsm_d;
  logic [BW-1:0]  baud_cnt;
  logic [2:0]     bit_cnt;
  logic [3:0]     gap_cnt;
  logic [4:0]     bytes_left;
  logic [127:0]   frame_q;
  logic           tx_d;
  logic           next_byte;
  logic           baud_end;
  logic           is_short;
  logic [7:0]     cur_byte;
  logic [2:0]     bit_nx;

  assign baud_end = (baud_cnt == BAUD_LAST);
  assign is_short = (state == 8'd9);
  assign cur_byte = frame_q[127:120];
  assign bit_nx   = bit_cnt + 3'd1;

  assign tx_busy = (fsm_q == S_START) || (fsm_q == S_DATA) ||
                   (fsm_q == S_STOP)  || (fsm_q == S_GAP);
  assign tx_done = (fsm_q == S_DONE);

  always_comb begin
    fsm_d     = fsm_q;
    next_byte = 1'b0;
    tx_d      = 1'b1;
    case (fsm_q)
      S_IDLE:  if (tx_start) fsm_d = S_START;
      S_START: if (baud_end) fsm_d = S_DATA;
      S_DATA:  if (baud_end && (bit_cnt == 3'd7)) fsm_d = S_STOP;
      S_STOP: begin
        if (baud_end) begin
          if (GAP_BITS != 0) begin
            fsm_d = S_GAP;
          end else if (bytes_left > 5'd1) begin
            fsm_d     = S_START;
            next_byte = 1'b1;
          end else begin
            fsm_d = S_DONE;
          end
        end
      end
      S_GAP: begin
        if (baud_end && (gap_cnt == GAP_LAST)) begin
          if (bytes_left > 5'd1) begin
            fsm_d     = S_START;
            next_byte = 1'b1;
          end else begin
            fsm_d = S_DONE;
          end
        end
      end
      S_DONE:  fsm_d = S_IDLE;
      default: fsm_d = S_IDLE;
    endcase

    // Line value is derived from the upcoming state so the registered pin lines up with fsm_q
    case (fsm_d)
      S_START: tx_d = 1'b0;
      S_DATA: begin
        if (fsm_q != S_DATA) tx_d = cur_byte[0];
        else if (baud_end)   tx_d = cur_byte[bit_nx];
        else                 tx_d = cur_byte[bit_cnt];
      end
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q      <= S_IDLE;
      uart_tx    <= 1'b1;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      bytes_left <= '0;
      frame_q    <= '0;
      word_cnt   <= '0;
    end else begin
      fsm_q   <= fsm_d;
      uart_tx <= tx_d;

      if ((fsm_q == S_IDLE) || baud_end || (fsm_d != fsm_q)) baud_cnt <= '0;
      else                                                   baud_cnt <= baud_cnt + 1'b1;

      if (fsm_q == S_DATA) begin
        if (baud_end) bit_cnt <= bit_nx;
      end else begin
        bit_cnt <= '0;
      end

      if (fsm_q == S_GAP) begin
        if (baud_end) gap_cnt <= gap_cnt + 4'd1;
      end else begin
        gap_cnt <= '0;
      end

      if ((fsm_q == S_IDLE) && tx_start) begin
        frame_q    <= is_short ? {tx_data[63:0], 64'h0} : tx_data;
        bytes_left <= is_short ? 5'd8 : 5'd16;
        word_cnt   <= '0;
      end else if (next_byte) begin
        frame_q    <= frame_q << 8;
        bytes_left <= bytes_left - 5'd1;
        // bytes_left == 1 mod 4 means the byte about to start opens a new word
        if (bytes_left[1:0] == 2'b01) word_cnt <= word_cnt + 2'd1;
      end else if (fsm_d == S_DONE) begin
        bytes_left <= '0;
        word_cnt   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_128bits.sv
// Randomized scoreboard bench for uart_tx_128bits at 4 clocks per bit.
module tb_uart_tx_128bits;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [7:0]   state;
  logic [127:0] tx_data;
  logic         tx_start;
  logic         tx_busy;
  logic         tx_done;
  logic [1:0]   word_cnt;
  logic         uart_tx;

  localparam int CPB = 4;

  uart_tx_128bits #(
    .CLK_FREQ(40_000_000),
    .BAUD    (10_000_000),
    .GAP_BITS(0)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .state   (state),
    .tx_data (tx_data),
    .tx_start(tx_start),
    .tx_busy (tx_busy),
    .tx_done (tx_done),
    .word_cnt(word_cnt),
    .uart_tx (uart_tx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] b;
    logic [1:0] w;
  } exp_t;

  exp_t    exp_q[$];
  longint  done_q[$];
  longint  cyc = 0;
  int      checks = 0;
  int      failures = 0;

  bit         mon_active = 0;
  int         mon_t = 0;
  logic [7:0] mon_byte;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // Reference: bytes leave MSB-first from the selected slice, 4 bytes per word.
  task automatic push_expect(input logic [127:0] d, input logic [7:0] st, input longint done_at);
    int unsigned nb;
    exp_t e;
    nb = (st == 8'd9) ? 8 : 16;
    for (int unsigned i = 0; i < nb; i++) begin
      e.b = d[(nb - 1 - i) * 8 +: 8];
      e.w = 2'(i / 4);
      exp_q.push_back(e);
    end
    done_q.push_back(done_at);
  endtask

  function automatic longint frame_cycles(input logic [7:0] st);
    return ((st == 8'd9) ? 8 : 16) * 10 * CPB;
  endfunction

  // Monitor: decodes the line by sampling mid-bit, compares against the scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      mon_active = 0;
    end else begin
      if (tx_done) begin
        if (done_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done actual=1 expected=0 at cycle %0d", cyc);
        end else begin
          chk("done_cycle", 128'(cyc), 128'(done_q.pop_front()));
          chk("busy_at_done", 128'(tx_busy), 128'(1'b0));
          chk("word_cnt_at_done", 128'(word_cnt), 128'(2'd0));
        end
      end
      if (!mon_active) begin
        if (uart_tx == 1'b0) begin
          mon_active = 1;
          mon_t = 0;
        end
      end else begin
        mon_t++;
        if (mon_t == 2) begin
          chk("start_bit", 128'(uart_tx), 128'(1'b0));
          if (exp_q.size() > 0) chk("word_cnt", 128'(word_cnt), 128'(exp_q[0].w));
        end else if ((mon_t >= 6) && (mon_t <= 34) && ((mon_t - 6) % 4 == 0)) begin
          mon_byte[(mon_t - 6) / 4] = uart_tx;
        end else if (mon_t == 38) begin
          chk("stop_bit", 128'(uart_tx), 128'(1'b1));
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_byte actual=%0h expected=none", mon_byte);
          end else begin
            chk("byte", 128'(mon_byte), 128'(exp_q.pop_front().b));
          end
          mon_active = 0;
        end
      end
    end
  end

  task automatic start_frame(input logic [127:0] d, input logic [7:0] st);
    @(posedge clk); #1;
    tx_data  = d;
    state    = st;
    tx_start = 1'b1;
    push_expect(d, st, cyc + 1 + frame_cycles(st));
    @(posedge clk); #1;
    tx_start = 1'b0;
    chk("busy_after_accept", 128'(tx_busy), 128'(1'b1));
    tx_data = {$urandom, $urandom, $urandom, $urandom};
    state   = 8'($urandom);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ((done_q.size() == 0) && (exp_q.size() == 0) && !tx_busy && !tx_done) begin
        ok = 1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL idle_timeout actual=busy expected=idle at cycle %0d", cyc);
      exp_q.delete();
      done_q.delete();
    end
  endtask

  localparam logic [127:0] VEC = 128'h00112233_44556677_8899AABB_CCDDEEFF;

  initial begin
    logic [127:0] d;
    logic [7:0]   st;
    bit           done_seen;

    rst_n    = 1'b0;
    state    = 8'd0;
    tx_data  = '0;
    tx_start = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_uart_tx", 128'(uart_tx), 128'(1'b1));
    chk("reset_busy", 128'(tx_busy), 128'(1'b0));
    chk("reset_done", 128'(tx_done), 128'(1'b0));
    chk("reset_word_cnt", 128'(word_cnt), 128'(2'd0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("idle_uart_tx", 128'(uart_tx), 128'(1'b1));
    chk("idle_busy", 128'(tx_busy), 128'(1'b0));

    // Full then short frame with the reference vector
    start_frame(VEC, 8'd0);
    wait_idle();
    start_frame(VEC, 8'd9);
    wait_idle();

    // Request while busy must be ignored
    start_frame(VEC, 8'd0);
    repeat (100) @(posedge clk);
    #1;
    tx_data  = ~VEC;
    state    = 8'd9;
    tx_start = 1'b1;
    @(posedge clk); #1;
    tx_start = 1'b0;
    wait_idle();

    // Request held through DONE is taken only on the following IDLE cycle
    start_frame(VEC, 8'd0);
    done_seen = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (tx_done) begin
        done_seen = 1;
        break;
      end
    end
    chk("b2b_done_seen", 128'(done_seen), 128'(1'b1));
    d = {$urandom, $urandom, $urandom, $urandom};
    tx_data  = d;
    state    = 8'd9;
    tx_start = 1'b1;
    push_expect(d, 8'd9, cyc + 2 + frame_cycles(8'd9));
    @(posedge clk); #1;
    chk("b2b_not_taken_in_done", 128'(tx_busy), 128'(1'b0));
    @(posedge clk); #1;
    chk("b2b_taken_in_idle", 128'(tx_busy), 128'(1'b1));
    tx_start = 1'b0;
    wait_idle();

    // Reset during byte 5 aborts without tx_done, then a clean frame follows
    start_frame({$urandom, $urandom, $urandom, $urandom}, 8'd0);
    repeat (190) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("abort_uart_tx", 128'(uart_tx), 128'(1'b1));
    chk("abort_busy", 128'(tx_busy), 128'(1'b0));
    chk("abort_word_cnt", 128'(word_cnt), 128'(2'd0));
    exp_q.delete();
    done_q.delete();
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    chk("post_abort_idle", 128'(uart_tx), 128'(1'b1));
    start_frame(VEC, 8'd0);
    wait_idle();

    // Randomized frames, roughly a third short
    for (int n = 0; n < 8; n++) begin
      d  = {$urandom, $urandom, $urandom, $urandom};
      st = ($urandom_range(0, 2) == 0) ? 8'd9 : 8'($urandom_range(0, 255));
      repeat ($urandom_range(0, 5)) @(posedge clk);
      start_frame(d, st);
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(5, 200)) @(posedge clk);
        #1;
        tx_data  = ~d;
        state    = 8'd9;
        tx_start = 1'b1;
        @(posedge clk); #1;
        tx_start = 1'b0;
      end
      wait_idle();
    end

    repeat (10) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
